// File: rtl/ps2_rx_frame_if.sv
// Byte-stream bus from the PS/2 receiver to the move/command decoder:
// one byte plus a one-cycle strobe per frame, and a one-cycle error strobe.
interface ps2_rx_frame_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] data;
  logic              data_en;
  logic              frame_err;

  modport master (output data, data_en, frame_err);
  modport slave  (input  data, data_en, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronise, filter PS2_CLK, deserialise 11-bit frames.
// Optional odd-parity checking is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           PS2_CLK,
  input  logic           PS2_DAT,
  ps2_rx_frame_if.master rx
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FILT_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic                clk_meta, clk_sync, dat_meta, dat_sync;
  logic [FILT_W-1:0]   filt_cnt;
  logic                clk_filt, clk_filt_d1;
  logic                fall;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_en_q, data_en_d;
  logic                frame_err_q, frame_err_d;
  logic                par_ok;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic                par_q, par_d;
`endif

  // Two-flop synchronisers; idle line level is high
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      filt_cnt    <= '0;
      clk_filt    <= 1'b1;
      clk_filt_d1 <= 1'b1;
    end else begin
      clk_filt_d1 <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  assign fall = clk_filt_d1 & ~clk_filt;

`ifdef PS2_RX_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  // Frame sequencing, strobe generation and inter-edge timeout
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = '0;
    data_d      = data_q;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    if (state_q != IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall && !dat_sync) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d[bit_cnt_q] = dat_sync;
          bit_cnt_d          = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_d = dat_sync;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dat_sync && par_ok) begin
            data_d    = shift_q;
            data_en_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fall) begin
      tmo_d = '0;
    end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end
  end

  assign rx.data      = data_q;
  assign rx.data_en   = data_en_q;
  assign rx.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomised and directed frame stimulus for ps2_rx_frame against a frame-level reference model.
module tb_ps2_rx_frame;
  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 300;
  localparam int unsigned HALF = 20;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .rx      (bus)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_total = 0, err_total = 0, both_cnt = 0, long_cnt = 0;
  int en_cyc = 0, stop_cyc = 0;
  logic prev_en = 1'b0, prev_err = 1'b0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (bus.data_en) begin
      en_total++;
      en_cyc = cyc;
    end
    if (bus.frame_err) err_total++;
    if (bus.data_en && bus.frame_err) both_cnt++;
    if ((bus.data_en && prev_en) || (bus.frame_err && prev_err)) long_cnt++;
    prev_en  = bus.data_en;
    prev_err = bus.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device drives data while clock is high, then pulls clock low
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(posedge Clock);
      #1 ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(posedge Clock);
      #1 ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge Clock);
    ps2_dat = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input logic stop, input string tag);
    int en0, err0;
    logic good;
    en0  = en_total;
    err0 = err_total;
    good = stop && (!PCHK || ((^b) ^ par));
    send_bits({stop, par, b, 1'b0}, 11);
    repeat (FILT + 10) @(posedge Clock);
    if (good) exp_data = b;
    check({tag, "_en"},   32'(en_total - en0),  good ? 32'd1 : 32'd0);
    check({tag, "_err"},  32'(err_total - err0), good ? 32'd0 : 32'd1);
    check({tag, "_data"}, 32'(bus.data), 32'(exp_data));
    if (good) check({tag, "_lat"}, 32'(en_cyc - stop_cyc), 32'(FILT + 3));
  endtask

  initial begin
    int en0, err0;
    logic [7:0] b;
    logic pgood;
    int kind;

    repeat (3) @(posedge Clock);
    #1;
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_en",   32'(bus.data_en), 32'd0);
    check("rst_err",  32'(bus.frame_err), 32'd0);
    Reset = 1'b0;
    repeat (10) @(posedge Clock);

    run_frame(8'h1D, 1'b1, 1'b1, "f1d");
    run_frame(8'hF0, 1'b1, 1'b1, "brk_f0");
    run_frame(8'h1D, 1'b1, 1'b1, "brk_1d");
    run_frame(8'h23, 1'b0, 1'b0, "stop0");
    run_frame(8'h5A, 1'b0, 1'b1, "par0");

    // Start plus four data bits, then the line stalls high
    en0 = en_total; err0 = err_total;
    send_bits(11'b000_0000_1010, 5);
    repeat (TMO + 20) @(posedge Clock);
    check("tmo_err",  32'(err_total - err0), 32'd1);
    check("tmo_en",   32'(en_total - en0), 32'd0);
    check("tmo_data", 32'(bus.data), 32'(exp_data));
    run_frame(8'h1C, 1'b0, 1'b1, "f1c");

    // Short low glitches must not get through the filter
    en0 = en_total; err0 = err_total;
    for (int g = 0; g < 3; g++) begin
      #1 ps2_clk = 1'b0;
      repeat (FILT - 1) @(posedge Clock);
      #1 ps2_clk = 1'b1;
      repeat (12) @(posedge Clock);
    end
    check("glitch_en",  32'(en_total - en0), 32'd0);
    check("glitch_err", 32'(err_total - err0), 32'd0);
    run_frame(8'h3C, 1'b1, 1'b1, "post_glitch");

    for (int r = 0; r < 12; r++) begin
      b     = 8'($urandom);
      kind  = int'($urandom_range(0, 2));
      pgood = ~(^b);
      run_frame(b, (kind == 1) ? ~pgood : pgood, (kind == 2) ? 1'b0 : 1'b1, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a frame
    send_bits(11'b000_0000_0110, 4);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(bus.data), 32'h00);
    check("mid_rst_en",   32'(bus.data_en), 32'd0);
    check("mid_rst_err",  32'(bus.frame_err), 32'd0);
    exp_data = 8'h00;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (10) @(posedge Clock);
    run_frame(8'h75, 1'b0, 1'b1, "post_rst");

    check("both_high",   32'(both_cnt), 32'd0);
    check("long_strobe", 32'(long_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
